// File: rtl/aes_frame_ctrl.sv
// aes_frame_ctrl: gathers 8 RX words (4 plaintext, 4 key) into one AES-128 job, starts the core,
// then streams the 4 ciphertext words to TX. Optional WAIT watchdog under `AES_TIMEOUT_EN.
module aes_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
`ifdef AES_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_dv,
    output logic [4*DATA_WIDTH-1:0] core_pt,
    output logic [4*DATA_WIDTH-1:0] core_key,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic [4*DATA_WIDTH-1:0] core_ct,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_dv,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err_overrun,
    output logic                    err_timeout
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned BLK_W = 4 * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        slot_c;
    logic [1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]  pt_q, pt_d;
    logic [BLK_W-1:0]  key_q, key_d;
    logic [BLK_W-1:0]  ct_q, ct_d;
    logic              core_start_q, core_start_d;
    logic              out_dv_q, out_dv_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              err_overrun_q, err_overrun_d;
    logic              timeout_c;

    // Word i of a 128-bit block, word 0 in the top bits.
    function automatic logic [W-1:0] blk_word(input logic [BLK_W-1:0] blk, input logic [1:0] i);
        case (i)
            2'd0:    blk_word = blk[BLK_W-1 -: W];
            2'd1:    blk_word = blk[BLK_W-1-W -: W];
            2'd2:    blk_word = blk[BLK_W-1-2*W -: W];
            default: blk_word = blk[W-1:0];
        endcase
    endfunction

    function automatic logic [BLK_W-1:0] blk_put(input logic [BLK_W-1:0] blk, input logic [1:0] i,
                                                 input logic [W-1:0] w);
        blk_put = blk;
        case (i)
            2'd0:    blk_put[BLK_W-1 -: W]     = w;
            2'd1:    blk_put[BLK_W-1-W -: W]   = w;
            2'd2:    blk_put[BLK_W-1-2*W -: W] = w;
            default: blk_put[W-1:0]            = w;
        endcase
    endfunction

    // A frame always begins at slot 0 from IDLE, whatever cnt holds.
    assign slot_c = (state_q == ST_IDLE) ? 3'd0 : cnt_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        pt_d          = pt_q;
        key_d         = key_q;
        ct_d          = ct_q;
        core_start_d  = 1'b0;
        out_dv_d      = 1'b0;
        out_data_d    = '0;
        err_overrun_d = err_overrun_q;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_dv) begin
                    if (!slot_c[2]) pt_d  = blk_put(pt_q, slot_c[1:0], in_data);
                    else            key_d = blk_put(key_q, slot_c[1:0], in_data);
                    if (slot_c == 3'd7) begin
                        cnt_d        = 3'd0;
                        state_d      = ST_START;
                        core_start_d = 1'b1;
                    end else begin
                        cnt_d   = slot_c + 3'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    ct_d       = core_ct;
                    idx_d      = 2'd0;
                    state_d    = ST_DRAIN;
                    out_dv_d   = 1'b1;
                    out_data_d = blk_word(core_ct, 2'd0);
                end else if (timeout_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                out_dv_d   = 1'b1;
                out_data_d = out_data_q;
                if (out_ready) begin
                    if (idx_q == 2'd3) begin
                        idx_d      = 2'd0;
                        state_d    = ST_IDLE;
                        out_dv_d   = 1'b0;
                        out_data_d = '0;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = blk_word(ct_q, idx_q + 2'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Words arriving while a job is in flight are dropped.
        if (in_dv && (state_q == ST_START || state_q == ST_WAIT || state_q == ST_DRAIN))
            err_overrun_d = 1'b1;

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            idx_q         <= 2'd0;
            pt_q          <= '0;
            key_q         <= '0;
            ct_q          <= '0;
            core_start_q  <= 1'b0;
            out_dv_q      <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pt_q          <= pt_d;
            key_q         <= key_d;
            ct_q          <= ct_d;
            core_start_q  <= core_start_d;
            out_dv_q      <= out_dv_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            err_overrun_q <= err_overrun_d;
        end
    end

`ifdef AES_TIMEOUT_EN
    localparam int unsigned WCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_timeout_q, err_timeout_d;

    // Counter is zero on WAIT entry; core_done on the final WAIT cycle still wins.
    assign timeout_c = (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wcnt_d        = (state_q == ST_WAIT) ? wcnt_q + WCNT_W'(1) : '0;
        err_timeout_d = err_timeout_q | ((state_q == ST_WAIT) && !core_done && timeout_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wcnt_q        <= wcnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_c   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign core_pt     = pt_q;
    assign core_key    = key_q;
    assign core_start  = core_start_q;
    assign out_dv      = out_dv_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign err_overrun = err_overrun_q;

endmodule
